muldiv_unit: RTL

- Iterative radix-2 multiply/divide execution unit for the core's M-extension-style ops.
- Sits between the register file and its write port:
  - Consumes the two read operands (rd1/rd2) and the destination index.
  - Takes 34 cycles from issue to a presented result.
  - Returns the 32-bit result through a valid/ready write-back request that the writeback arbiter forwards to the register file's we/wa/wd.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and operation-class helpers.
package muldiv_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULH  = 3'd1;
    localparam logic [2:0] OP_MULHU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_REM   = 3'd5;
    localparam logic [2:0] OP_REMU  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit: 32 shift-add or restoring shift-subtract
// steps on magnitudes, then a single sign-fix cycle and a valid/ready write-back.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [AW-1:0]   in_wa,
    input  logic            kill,
    output logic            busy,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [AW-1:0]   wb_wa,
    output logic [XLEN-1:0] wb_wd
);

    localparam int CW = $clog2(ITER);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [AW-1:0]       wa_q, wa_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     dsr_q, dsr_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [AW-1:0]       wb_wa_q, wb_wa_d;
    logic [XLEN-1:0]     wb_wd_q, wb_wd_d;

    logic [2:0]          issue_op;
    logic                issue_sgn;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, result;

    assign issue_op  = (in_op == 3'b111) ? OP_MUL : in_op;
    assign issue_sgn = is_signed_op(issue_op);
    assign a_abs     = (issue_sgn && in_a[XLEN-1]) ? -in_a : in_a;
    assign b_abs     = (issue_sgn && in_b[XLEN-1]) ? -in_b : in_b;

    // hi holds the running product high half / partial remainder; lo holds the
    // multiplier / dividend, which is shifted out as quotient bits are shifted in.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, dsr_q};

    assign prod_fix = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quot_fix = (dsr_q == '0) ? '1 : (neg_res_q ? -lo_q : lo_q);
    // With b=0 every trial subtract succeeds, so hi is |a| and the sign fix restores a.
    assign rem_fix  = neg_rem_q ? -hi_q : hi_q;

    always_comb begin
        case (op_q)
            OP_MULH, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:   result = quot_fix;
            OP_REM, OP_REMU:   result = rem_fix;
            default:           result = prod_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        wa_d      = wa_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dsr_d     = dsr_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        wb_wa_d   = wb_wa_q;
        wb_wd_d   = wb_wd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    op_d      = issue_op;
                    wa_d      = in_wa;
                    hi_d      = '0;
                    lo_d      = a_abs;
                    dsr_d     = b_abs;
                    neg_res_d = issue_sgn && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                    neg_rem_d = issue_sgn && in_a[XLEN-1];
                end
            end
            ST_CALC: begin
                if (is_div_op(op_q)) begin
                    hi_d = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                wb_wd_d = result;
                wb_wa_d = wa_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
            wb_wd_d = wb_wd_q;
            wb_wa_d = wb_wa_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            wa_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dsr_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            wb_wa_q   <= '0;
            wb_wd_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            wa_q      <= wa_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dsr_q     <= dsr_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            wb_wa_q   <= wb_wa_d;
            wb_wd_q   <= wb_wd_d;
        end
    end

    assign in_ready = rst && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign wb_valid = (state_q == ST_DONE);
    assign wb_wa    = wb_wa_q;
    assign wb_wd    = wb_wd_q;

endmodule
